exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-002 SHALL have inputs from MEM stage: inst_valid_i 1 (valid instruction present); pc_i 32; is_in_delayslot_i 1; mem_addr_i 32 (load/store address); exc_flags_i 8, one-hot-or-more: [0] fetch ADEL, [1] RI, [2] OV, [3] SYSCALL, [4] BREAK, [5] load ADEL, [6] store ADES, [7] ERET.
REQ-003 SHALL have inputs from CP0: status_i 32, cause_i 32, epc_i 32; and mem_busy_i 1 (AXI data transaction outstanding).
REQ-004 SHALL have CP0-facing outputs: excepttype_o 32, current_inst_addr_o 32, is_in_delayslot_o 1, bad_addr_o 32.
REQ-005 SHALL have pipeline outputs: flush_o 1 (kill all stages), stall_o 1 (freeze all stages), newpc_o 32 (redirect target, valid while flush_o=1).
REQ-006 SHALL use parameter EXC_VECTOR, default 32'hBFC00380, general exception entry address.

Function
REQ-007 SHALL compute int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]); interrupt is taken only when int_pend & inst_valid_i.
REQ-008 SHALL select one cause by fixed priority, highest first: interrupt 0x01, fetch ADEL 0x04, RI 0x0a, OV 0x0c, SYSCALL 0x08, BREAK 0x09, load ADEL 0x04, store ADES 0x05, ERET 0x0e; exc_flags_i ignored when inst_valid_i=0.
REQ-009 SHALL set bad address = pc_i for fetch ADEL, mem_addr_i for load ADEL/ADES, 0 otherwise.
REQ-010 SHALL implement FSM states IDLE, WAIT_MEM, COMMIT.
REQ-011 IDLE: on detected cause with mem_busy_i=0 -> COMMIT; with mem_busy_i=1 -> WAIT_MEM; else stay IDLE.
REQ-012 On leaving IDLE SHALL latch code, pc_i, is_in_delayslot_i, bad address into internal registers.
REQ-013 WAIT_MEM: stall_o=1; new detections ignored; move to COMMIT in the cycle after mem_busy_i is sampled 0.
REQ-014 COMMIT: exactly one cycle; excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o drive latched values; flush_o=1; next state IDLE unconditionally.
REQ-015 newpc_o in COMMIT SHALL be epc_i (sampled that cycle) for code 0x0e, else EXC_VECTOR.
REQ-016 Outside COMMIT excepttype_o SHALL be 0, flush_o 0, and current_inst_addr_o/is_in_delayslot_o/bad_addr_o/newpc_o 0, so CP0 never acts twice.
REQ-017 Latency: detection cycle N with mem_busy_i=0 -> excepttype_o/flush_o asserted in cycle N+1; with busy ending (sampled 0) in cycle M -> COMMIT in M+1.
REQ-018 stall_o SHALL be 0 in IDLE and COMMIT.
REQ-019 Detection in COMMIT cycle SHALL be ignored (flushed instruction).
REQ-020 Multiple flags set simultaneously SHALL resolve only by REQ-008 priority; one commit per event.

Reset
REQ-021 rst=0 SHALL asynchronously force state IDLE, all latched registers 0, all outputs 0.
REQ-022 Reset during WAIT_MEM or COMMIT SHALL abandon the pending exception without emitting excepttype_o.
REQ-023 After rst deasserts, first detection SHALL be possible on the first rising edge.

Structure
REQ-024 Exception codes (0x01,0x04,0x05,0x08,0x09,0x0a,0x0c,0x0e), EXC_VECTOR value and FSM state encodings SHALL live in the shared defines2.vh.
REQ-025 Priority selection SHALL be one combinational sub-module exc_prio (flags, int_pend, pc, addr -> code, bad address); FSM and registers in exception_ctrl.

Verification
REQ-026 Idle, exc_flags_i[2]=1, pc_i=0xBFC00100, busy=0 -> next cycle excepttype_o=0x0c, current_inst_addr_o=0xBFC00100, flush_o=1, newpc_o=0xBFC00380; following cycle all 0.
REQ-027 exc_flags_i[6]=1, mem_addr_i=0x80000003, busy=1 for 3 cycles -> stall_o=1 for those cycles, then excepttype_o=0x05, bad_addr_o=0x80000003, single-cycle flush.
REQ-028 status_i=0x0000FF01, cause_i=0x00008000, exc_flags_i=0x09 -> interrupt wins: excepttype_o=0x01, bad_addr_o=0.
REQ-029 exc_flags_i[7]=1, epc_i=0xBFC00200 -> excepttype_o=0x0e, newpc_o=0xBFC00200; with status_i[1]=1 an asserted interrupt is not taken.
REQ-030 rst=0 mid WAIT_MEM -> outputs 0 immediately; after release with busy=0 no excepttype_o pulse occurs.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl_pkg
// Description : Shared definitions for the exception controller: exception
//               codes, the default exception entry vector, exc_flags_i bit
//               positions and the FSM state encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package exception_ctrl_pkg;

  // Exception codes as written into CP0 excepttype
  localparam logic [7:0] c_exc_none = 8'h00;
  localparam logic [7:0] c_exc_int  = 8'h01;
  localparam logic [7:0] c_exc_adel = 8'h04;
  localparam logic [7:0] c_exc_ades = 8'h05;
  localparam logic [7:0] c_exc_sys  = 8'h08;
  localparam logic [7:0] c_exc_bp   = 8'h09;
  localparam logic [7:0] c_exc_ri   = 8'h0a;
  localparam logic [7:0] c_exc_ov   = 8'h0c;
  localparam logic [7:0] c_exc_eret = 8'h0e;

  // General exception entry address
  localparam logic [31:0] c_exc_vector = 32'hBFC00380;

  // Bit positions inside exc_flags_i
  localparam int c_flag_fetch_adel = 0;
  localparam int c_flag_ri         = 1;
  localparam int c_flag_ov         = 2;
  localparam int c_flag_sys        = 3;
  localparam int c_flag_bp         = 4;
  localparam int c_flag_load_adel  = 5;
  localparam int c_flag_store_ades = 6;
  localparam int c_flag_eret       = 7;

  // FSM state encodings
  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_wait_mem = 2'd1;
  localparam logic [1:0] c_st_commit   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = c_st_idle,
    ST_WAIT_MEM = c_st_wait_mem,
    ST_COMMIT   = c_st_commit
  } state_t;

endpackage : exception_ctrl_pkg
`default_nettype wire

// File: rtl/exception_ctrl_prio.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio
// Description : Combinational fixed-priority exception selector. Picks one
//               exception code out of the pending interrupt and the MEM-stage
//               flags and produces the matching bad virtual address.
// Ports       : i_flags     [7:0]  exception flags (already gated by valid)
//               i_int_pend         interrupt to be taken (already gated)
//               i_pc        [31:0] PC of the instruction
//               i_addr      [31:0] load/store data address
//               o_code      [7:0]  selected exception code, 0 when none
//               o_bad_addr  [31:0] bad address for address errors, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio
  import exception_ctrl_pkg::*;
(
  input  logic [7:0]  i_flags,
  input  logic        i_int_pend,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_addr,
  output logic [7:0]  o_code,
  output logic [31:0] o_bad_addr
);

  always_comb begin
    o_code     = c_exc_none;
    o_bad_addr = 32'h0;
    if (i_int_pend) begin
      o_code = c_exc_int;
    end else if (i_flags[c_flag_fetch_adel]) begin
      o_code     = c_exc_adel;
      o_bad_addr = i_pc;
    end else if (i_flags[c_flag_ri]) begin
      o_code = c_exc_ri;
    end else if (i_flags[c_flag_ov]) begin
      o_code = c_exc_ov;
    end else if (i_flags[c_flag_sys]) begin
      o_code = c_exc_sys;
    end else if (i_flags[c_flag_bp]) begin
      o_code = c_exc_bp;
    end else if (i_flags[c_flag_load_adel]) begin
      o_code     = c_exc_adel;
      o_bad_addr = i_addr;
    end else if (i_flags[c_flag_store_ades]) begin
      o_code     = c_exc_ades;
      o_bad_addr = i_addr;
    end else if (i_flags[c_flag_eret]) begin
      o_code = c_exc_eret;
    end
  end

endmodule : exc_prio
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl
// Description : MEM-stage exception controller. Detects interrupts and
//               exceptions, waits for any outstanding data-bus transaction,
//               then issues a single-cycle commit to CP0 together with a
//               pipeline flush and redirect PC.
// Ports       : clk                       clock, rising edge
//               rst                       asynchronous reset, active low
//               inst_valid_i              valid instruction in MEM
//               pc_i [31:0]               instruction PC
//               is_in_delayslot_i         instruction sits in a delay slot
//               mem_addr_i [31:0]         load/store address
//               exc_flags_i [7:0]         raw exception flags
//               status_i/cause_i/epc_i    CP0 registers
//               mem_busy_i                data transaction outstanding
//               excepttype_o [31:0]       exception code (COMMIT only)
//               current_inst_addr_o [31:0]faulting PC (COMMIT only)
//               is_in_delayslot_o         delay-slot flag (COMMIT only)
//               bad_addr_o [31:0]         bad virtual address (COMMIT only)
//               flush_o                   kill all pipeline stages
//               stall_o                   freeze all pipeline stages
//               newpc_o [31:0]            redirect target (COMMIT only)
// Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = c_exc_vector
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        mem_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic [31:0] newpc_o
);

  logic        w_int_pend;
  logic        w_int_take;
  logic [7:0]  w_flags;
  logic [7:0]  w_code;
  logic [31:0] w_bad_addr;
  logic        w_detect;
  logic        w_unused_bits;

  state_t      r_state;
  logic [7:0]  r_code;
  logic [31:0] r_pc;
  logic        r_ds;
  logic [31:0] r_bad_addr;

  // Interrupts enabled (IE=1), not already in exception level (EXL=0) and at
  // least one unmasked pending line.
  assign w_int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign w_int_take = w_int_pend & inst_valid_i;
  assign w_flags    = inst_valid_i ? exc_flags_i : 8'h00;

  // CP0 fields this block does not look at
  assign w_unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  exc_prio u_exc_prio (
    .i_flags    (w_flags),
    .i_int_pend (w_int_take),
    .i_pc       (pc_i),
    .i_addr     (mem_addr_i),
    .o_code     (w_code),
    .o_bad_addr (w_bad_addr)
  );

  assign w_detect = (w_code != c_exc_none);

  // The commit outputs are cleared every cycle and only loaded on the edge
  // that enters COMMIT, so they are non-zero for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= ST_IDLE;
      r_code              <= c_exc_none;
      r_pc                <= 32'h0;
      r_ds                <= 1'b0;
      r_bad_addr          <= 32'h0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      stall_o             <= 1'b0;
    end else begin
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      stall_o             <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_detect) begin
            r_code     <= w_code;
            r_pc       <= pc_i;
            r_ds       <= is_in_delayslot_i;
            r_bad_addr <= w_bad_addr;
            if (mem_busy_i) begin
              r_state <= ST_WAIT_MEM;
              stall_o <= 1'b1;
            end else begin
              r_state             <= ST_COMMIT;
              flush_o             <= 1'b1;
              excepttype_o        <= {24'h0, w_code};
              current_inst_addr_o <= pc_i;
              is_in_delayslot_o   <= is_in_delayslot_i;
              bad_addr_o          <= w_bad_addr;
            end
          end
        end
        ST_WAIT_MEM: begin
          // New detections are ignored here; the pipeline is frozen.
          if (mem_busy_i) begin
            stall_o <= 1'b1;
          end else begin
            r_state             <= ST_COMMIT;
            flush_o             <= 1'b1;
            excepttype_o        <= {24'h0, r_code};
            current_inst_addr_o <= r_pc;
            is_in_delayslot_o   <= r_ds;
            bad_addr_o          <= r_bad_addr;
          end
        end
        ST_COMMIT: begin
          // The instruction seen now is being flushed, so it cannot raise.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // EPC is taken live in the COMMIT cycle so a same-cycle CP0 update of EPC
  // is honoured by ERET.
  assign newpc_o = (r_state == ST_COMMIT)
                 ? ((r_code == c_exc_eret) ? epc_i : EXC_VECTOR)
                 : 32'h0;

endmodule : exception_ctrl
`default_nettype wire
